pll_lock_supervisor: RTL and testbench

//  Supervises a PLL: synchronises and debounces its locked output, retries the PLL via its reset on lock timeout.

---
 rtl/pll_lock_supervisor.sv | 186 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises the PLL locked flag, retries the PLL on
// lock timeout, releases N_CH active-low resets in a staggered sequence once
// lock is stable, and counts loss-of-lock events.
module pll_lock_supervisor #(
  parameter int N_CH           = 4,
  parameter int STABLE_CYCLES  = 1024,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PLL_RST_CYCLES = 32,
  parameter int TIMER_W        = 18,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             clr_lol,
  output logic             pll_rst,
  output logic [N_CH-1:0]  rst_n_out,
  output logic             ready,
  output logic             lol_sticky,
  output logic [CNT_W-1:0] lol_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Terminal timer values: each phase ends on the cycle its timer hits these.
  localparam logic [TIMER_W-1:0] LP_RST_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LP_TO_LAST     = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LP_STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LP_GAP_LAST    = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [N_CH-1:0]    LP_FIRST       = N_CH'(1);

  // Saturating increment for the loss-of-lock counter (sticks at all-ones).
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic               r_sync1;
  logic               r_sync2;
  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_pll_rst;
  logic [N_CH-1:0]    r_rst_n;
  logic               r_ready;
  logic               r_sticky;
  logic [CNT_W-1:0]   r_count;

  state_t             w_state_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [N_CH-1:0]    w_rst_n_nxt;
  logic [N_CH-1:0]    w_rst_shift;
  logic               w_loss;
  logic               w_lock_s;

  assign w_lock_s    = r_sync2;
  // Thermometer step: releases the next channel above those already released.
  assign w_rst_shift = (r_rst_n << 1) | LP_FIRST;

  // Two-flop synchroniser for the asynchronous PLL locked flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, shared timer and release-pattern decode.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rst_n_nxt = r_rst_n;
    w_loss      = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_timer == LP_RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = S_STABLE;
          w_timer_nxt = '0;
        end else if (r_timer == LP_TO_LAST) begin
          w_state_nxt = S_PLL_RST;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      S_STABLE: begin
        // A drop here is just an unstable lock, not a loss event.
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_timer == LP_STABLE_LAST) begin
          // A single channel completes the whole sequence on this edge.
          w_state_nxt = (N_CH == 1) ? S_RUN : S_RELEASE;
          w_timer_nxt = '0;
          w_rst_n_nxt = LP_FIRST;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      S_RELEASE: begin
        if (!w_lock_s) begin
          w_loss = 1'b1;
        end else if (r_timer == LP_GAP_LAST) begin
          w_timer_nxt = '0;
          w_rst_n_nxt = w_rst_shift;
          if (&w_rst_shift) begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_loss = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_timer_nxt = '0;
        w_rst_n_nxt = '0;
      end
    endcase
    if (w_loss) begin
      w_state_nxt = S_WAIT_LOCK;
      w_timer_nxt = '0;
      w_rst_n_nxt = '0;
    end
  end

  // State register plus registered PLL reset, channel resets and ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_PLL_RST;
      r_timer   <= '0;
      r_pll_rst <= 1'b1;
      r_rst_n   <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_pll_rst <= (w_state_nxt == S_PLL_RST);
      r_rst_n   <= w_rst_n_nxt;
      r_ready   <= (w_state_nxt == S_RUN);
    end
  end

  // Loss-of-lock bookkeeping; a loss in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_loss) begin
      r_sticky <= 1'b1;
      r_count  <= clr_lol ? CNT_W'(1) : sat_inc(r_count);
    end else if (clr_lol) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end
  end

  assign pll_rst    = r_pll_rst;
  assign rst_n_out  = r_rst_n;
  assign ready      = r_ready;
  assign lol_sticky = r_sticky;
  assign lol_count  = r_count;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: phase/age reference model plus
// directed scenarios with hand-computed cycle positions.
module tb_pll_lock_supervisor;
  localparam int N   = 3;
  localparam int ST  = 8;
  localparam int GAP = 4;
  localparam int TO  = 64;
  localparam int PR  = 4;
  localparam int TW  = 18;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          clr_lol;
  logic          pll_rst;
  logic [N-1:0]  rst_n_out;
  logic          ready;
  logic          lol_sticky;
  logic [CW-1:0] lol_count;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .N_CH(N), .STABLE_CYCLES(ST), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO),
    .PLL_RST_CYCLES(PR), .TIMER_W(TW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .clr_lol(clr_lol),
    .pll_rst(pll_rst), .rst_n_out(rst_n_out), .ready(ready),
    .lol_sticky(lol_sticky), .lol_count(lol_count), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 pulsing PLL reset, 1 waiting for lock,
  // 2 counting stable lock, 3 released (age = cycles since first release).
  int m_mode = 0;
  int m_age  = 0;
  int m_cnt  = 0;
  bit m_sticky = 1'b0;
  bit m_hist[$] = '{1'b0, 1'b0};

  always @(posedge clk or negedge reset_n) begin
    bit ls;
    bit loss;
    logic [N-1:0] e_rst;
    bit e_ready;
    int e_state;
    if (!reset_n) begin
      m_mode = 0; m_age = 0; m_cnt = 0; m_sticky = 1'b0;
      m_hist = '{1'b0, 1'b0};
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(pll_locked);
      loss = (m_mode == 3) && !ls;
      if (loss) begin
        m_sticky = 1'b1;
        m_cnt = clr_lol ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      end else if (clr_lol) begin
        m_sticky = 1'b0;
        m_cnt = 0;
      end
      case (m_mode)
        0: begin
          m_age++;
          if (m_age == PR) begin m_mode = 1; m_age = 0; end
        end
        1: begin
          if (ls) begin m_mode = 2; m_age = 0; end
          else begin
            m_age++;
            if (m_age == TO) begin m_mode = 0; m_age = 0; end
          end
        end
        2: begin
          if (!ls) begin m_mode = 1; m_age = 0; end
          else begin
            m_age++;
            if (m_age == ST) begin m_mode = 3; m_age = 0; end
          end
        end
        default: begin
          if (loss) begin m_mode = 1; m_age = 0; end
          else if (m_age < 10000) m_age++;
        end
      endcase
    end
    #2;
    for (int k = 0; k < N; k++) e_rst[k] = (m_mode == 3) && (m_age >= k * GAP);
    e_ready = (m_mode == 3) && (m_age >= (N - 1) * GAP);
    e_state = (m_mode < 3) ? m_mode : (e_ready ? 4 : 3);
    chk("m_pll_rst", pll_rst, (m_mode == 0));
    chk("m_rst_n_out", rst_n_out, e_rst);
    chk("m_ready", ready, e_ready);
    chk("m_sticky", lol_sticky, m_sticky);
    chk("m_count", lol_count, m_cnt);
    chk("m_state", state_dbg, e_state);
  end

  task automatic wait_rel0();
    for (int w = 0; w < 200 && rst_n_out[0] !== 1'b1; w++) @(negedge clk);
    chk("wait_release", rst_n_out[0], 1);
  endtask

  initial begin
    reset_n = 1'b0; pll_locked = 1'b0; clr_lol = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_state", state_dbg, 0);
    chk("rst_rst_n_out", rst_n_out, 0);
    chk("rst_ready", ready, 0);
    reset_n = 1'b1;

    // 1: no lock, periodic PLL reset pulses
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (k == 3 || k == 68 || k == 71 || k == 136) chk("t1_pll_rst_hi", pll_rst, 1);
      if (k == 4 || k == 67 || k == 72) chk("t1_pll_rst_lo", pll_rst, 0);
    end

    // 2: lock arrives, staggered release
    pll_locked = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      if (j == 10) chk("t2_pre_bit0", rst_n_out, 3'b000);
      if (j == 11) chk("t2_bit0", rst_n_out, 3'b001);
      if (j == 14) chk("t2_pre_bit1", rst_n_out, 3'b001);
      if (j == 15) chk("t2_bit1", rst_n_out, 3'b011);
      if (j == 18) chk("t2_pre_ready", ready, 0);
      if (j == 19) begin
        chk("t2_bit2", rst_n_out, 3'b111);
        chk("t2_ready", ready, 1);
        chk("t2_count", lol_count, 0);
      end
    end

    // 4 + 3: loss in RUN, then a drop during STABLE before final release
    pll_locked = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      if (j == 2) chk("t4_still_run", rst_n_out, 3'b111);
      if (j == 3) begin
        chk("t4_rst_low", rst_n_out, 3'b000);
        chk("t4_ready_low", ready, 0);
        chk("t4_sticky", lol_sticky, 1);
        chk("t4_count", lol_count, 1);
      end
      if (j == 22) chk("t3_pre_rel", rst_n_out, 3'b000);
      if (j == 23) begin
        chk("t3_rel", rst_n_out, 3'b001);
        chk("t3_count", lol_count, 1);
      end
      if (j == 30) chk("t3_pre_ready", ready, 0);
      if (j == 31) chk("t3_ready", ready, 1);
      if (j == 5 || j == 12) pll_locked = 1'b1;
      if (j == 9) pll_locked = 1'b0;
    end

    // clear alone
    clr_lol = 1'b1;
    @(negedge clk);
    clr_lol = 1'b0;
    chk("clr_sticky", lol_sticky, 0);
    chk("clr_count", lol_count, 0);

    // 5: 17 loss events, saturation at 15
    for (int i = 1; i <= 17; i++) begin
      wait_rel0();
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (2) @(negedge clk);
      if (i == 1) chk("t5_count1", lol_count, 1);
      if (i == 14) chk("t5_count14", lol_count, 14);
      if (i == 15) chk("t5_count15", lol_count, 15);
      if (i == 17) begin
        chk("t5_sat", lol_count, 15);
        chk("t5_sticky", lol_sticky, 1);
      end
    end
    // 18th loss coinciding with clear
    wait_rel0();
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    @(negedge clk);
    clr_lol = 1'b1;
    @(negedge clk);
    clr_lol = 1'b0;
    chk("t5_clr_loss_sticky", lol_sticky, 1);
    chk("t5_clr_loss_count", lol_count, 1);
    chk("t5_clr_loss_rst", rst_n_out, 3'b000);

    // 6: asynchronous reset mid-RELEASE
    for (int w = 0; w < 200 && rst_n_out !== 3'b001; w++) @(negedge clk);
    chk("t6_mid_release", rst_n_out, 3'b001);
    chk("t6_state_rel", state_dbg, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_pll_rst", pll_rst, 1);
    chk("t6_rst_n_out", rst_n_out, 0);
    chk("t6_ready", ready, 0);
    chk("t6_sticky", lol_sticky, 0);
    chk("t6_count", lol_count, 0);
    chk("t6_state", state_dbg, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
